// File: rtl/brisc_pkg.sv
// brisc_pkg: shared core parameters and the memory arbiter's enums.
// Also provides line_align() for line-granular memory addresses.
package brisc_pkg;

  localparam int ADDRESS_WIDTH    = 32;
  localparam int CACHE_LINE_WIDTH = 128;
  localparam int BYTE_WIDTH       = 8;
  localparam int MEM_REQ_DELAY    = 5;
  localparam int MEM_RESP_DELAY   = 5;

  localparam int LINE_OFFSET =
    $clog2(CACHE_LINE_WIDTH / BYTE_WIDTH);

  typedef logic [ADDRESS_WIDTH-1:0]    addr_t;
  typedef logic [CACHE_LINE_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FILL,
    RESP,
    DRAIN
  } mem_arb_state_e;

  typedef enum logic {
    IC,
    DC
  } mem_client_e;

  function automatic addr_t line_align(addr_t a);
    return {a[ADDRESS_WIDTH-1:LINE_OFFSET], LINE_OFFSET'(0)};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, dcache and memory-port signals of the arbiter.
// master = arbiter side, slave = caches plus memory model side.
interface mem_arbiter_if;
  import brisc_pkg::*;

  logic  ic_req;
  addr_t ic_req_addr;
  logic  ic_fill;
  line_t ic_fill_data;

  logic  dc_req;
  logic  dc_req_store;
  addr_t dc_req_addr;
  line_t dc_req_evict_data;
  logic  dc_fill;
  line_t dc_fill_data;
  logic  dc_store_ack;

  logic  mem_req;
  logic  mem_req_store;
  addr_t mem_req_addr;
  line_t mem_req_evict_data;
  logic  mem_fill;
  line_t mem_fill_data;
  addr_t mem_fill_addr;

  modport master (
    input  ic_req, ic_req_addr,
    output ic_fill, ic_fill_data,
    input  dc_req, dc_req_store, dc_req_addr,
    input  dc_req_evict_data,
    output dc_fill, dc_fill_data, dc_store_ack,
    output mem_req, mem_req_store, mem_req_addr,
    output mem_req_evict_data,
    input  mem_fill, mem_fill_data, mem_fill_addr
  );

  modport slave (
    output ic_req, ic_req_addr,
    input  ic_fill, ic_fill_data,
    output dc_req, dc_req_store, dc_req_addr,
    output dc_req_evict_data,
    input  dc_fill, dc_fill_data, dc_store_ack,
    input  mem_req, mem_req_store, mem_req_addr,
    input  mem_req_evict_data,
    output mem_fill, mem_fill_data, mem_fill_addr
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester (IC/DC) round-robin arbiter.
// Ports: clk, reset_n, req_ic/req_dc in, update in (grant taken), gnt_ic/gnt_dc out.
module rr_arb2
  import brisc_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_ic,
  input  logic req_dc,
  input  logic update,
  output logic gnt_ic,
  output logic gnt_dc
);

  mem_client_e prio_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio_q <= DC;
    end else if (update) begin
      prio_q <= gnt_ic ? DC : IC;
    end
  end

  always_comb begin
    gnt_ic = req_ic && (!req_dc || prio_q == IC);
    gnt_dc = req_dc && (!req_ic || prio_q == DC);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache/dcache misses and evictions onto one memory port.
// Ports: clk, reset_n, bus (mem_arbiter_if.master), err (sticky protocol error).
module mem_arbiter #(
  parameter int MEM_REQ_DELAY  = brisc_pkg::MEM_REQ_DELAY,
  parameter int MEM_RESP_DELAY = brisc_pkg::MEM_RESP_DELAY,
  parameter int FILL_TIMEOUT   = MEM_RESP_DELAY + 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_arbiter_if.master        bus,
  output logic                 err
);
  import brisc_pkg::*;

  localparam int CMAX =
    FILL_TIMEOUT > MEM_REQ_DELAY ? FILL_TIMEOUT : MEM_REQ_DELAY;
  localparam int CW = $clog2(CMAX + 1);

  mem_arb_state_e state_q, state_d;
  mem_client_e    owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           req_q, req_d;
  logic           store_q, store_d;
  addr_t          addr_q, addr_d;
  line_t          evict_q, evict_d;
  logic           ic_fill_q, ic_fill_d;
  line_t          ic_data_q, ic_data_d;
  logic           dc_fill_q, dc_fill_d;
  line_t          dc_data_q, dc_data_d;
  logic           ack_q, ack_d;

  logic gnt_ic, gnt_dc, upd;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req_ic  (bus.ic_req),
    .req_dc  (bus.dc_req),
    .update  (upd),
    .gnt_ic  (gnt_ic),
    .gnt_dc  (gnt_dc)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req_d     = 1'b0;
    store_d   = store_q;
    addr_d    = addr_q;
    evict_d   = evict_q;
    ic_fill_d = 1'b0;
    ic_data_d = ic_data_q;
    dc_fill_d = 1'b0;
    dc_data_d = dc_data_q;
    ack_d     = 1'b0;
    upd       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_ic || gnt_dc) begin
          upd     = 1'b1;
          req_d   = 1'b1;
          owner_d = gnt_ic ? IC : DC;
          addr_d  = gnt_ic ? line_align(bus.ic_req_addr)
                           : line_align(bus.dc_req_addr);
          if (gnt_dc && bus.dc_req_store) begin
            store_d = 1'b1;
            evict_d = bus.dc_req_evict_data;
            ack_d   = 1'b1;
            cnt_d   = CW'(MEM_REQ_DELAY);
            state_d = DRAIN;
          end else begin
            store_d = 1'b0;
            cnt_d   = CW'(FILL_TIMEOUT);
            state_d = WAIT_FILL;
          end
        end
      end
      WAIT_FILL: begin
        cnt_d = cnt_q - CW'(1);
        if (bus.mem_fill && bus.mem_fill_addr == addr_q) begin
          if (owner_q == IC) begin
            ic_fill_d = 1'b1;
            ic_data_d = bus.mem_fill_data;
          end else begin
            dc_fill_d = 1'b1;
            dc_data_d = bus.mem_fill_data;
          end
          state_d = RESP;
        end else begin
          if (bus.mem_fill) err_d = 1'b1;
          // Requester still holds req, so IDLE re-issues it.
          if (cnt_q == CW'(1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= IC;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      store_q   <= 1'b0;
      addr_q    <= '0;
      evict_q   <= '0;
      ic_fill_q <= 1'b0;
      ic_data_q <= '0;
      dc_fill_q <= 1'b0;
      dc_data_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      req_q     <= req_d;
      store_q   <= store_d;
      addr_q    <= addr_d;
      evict_q   <= evict_d;
      ic_fill_q <= ic_fill_d;
      ic_data_q <= ic_data_d;
      dc_fill_q <= dc_fill_d;
      dc_data_q <= dc_data_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.mem_req            = req_q;
  assign bus.mem_req_store      = store_q;
  assign bus.mem_req_addr       = addr_q;
  assign bus.mem_req_evict_data = evict_q;
  assign bus.ic_fill            = ic_fill_q;
  assign bus.ic_fill_data       = ic_data_q;
  assign bus.dc_fill            = dc_fill_q;
  assign bus.dc_fill_data       = dc_data_q;
  assign bus.dc_store_ack       = ack_q;
  assign err                    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a memory model
// and a fill scoreboard.
module tb_mem_arbiter;
  import brisc_pkg::*;

  localparam int RQD = 5;
  localparam int RSD = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   auto_resp = 1'b1;

  mem_arbiter_if bus();

  mem_arbiter #(
    .MEM_REQ_DELAY  (RQD),
    .MEM_RESP_DELAY (RSD),
    .FILL_TIMEOUT   (RSD + 2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; addr_t a; line_t d;} fire_t;
  typedef struct {int c; logic st; addr_t a; line_t d;} log_t;
  typedef struct {mem_client_e who; line_t d; int c;} exp_t;

  fire_t fire_q[$];
  fire_t wr_q[$];
  log_t  log_q[$];
  exp_t  exp_q[$];
  line_t mem [addr_t];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic line_t rd_line(addr_t a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'h1111_0000};
  endfunction

  // Memory model: reads see memory at issue; stores land RQD later.
  always @(posedge clk) begin
    if (bus.mem_req) begin
      log_q.push_back('{cyc, bus.mem_req_store, bus.mem_req_addr,
                        bus.mem_req_evict_data});
      if (bus.mem_req_store)
        wr_q.push_back('{cyc + RQD, bus.mem_req_addr,
                         bus.mem_req_evict_data});
      else if (auto_resp)
        fire_q.push_back('{cyc + RSD, bus.mem_req_addr,
                           rd_line(bus.mem_req_addr)});
    end
    while (wr_q.size() > 0 && wr_q[0].c <= cyc) begin
      mem[wr_q[0].a] = wr_q[0].d;
      void'(wr_q.pop_front());
    end
    #1;
    bus.mem_fill      = 1'b0;
    bus.mem_fill_addr = '0;
    bus.mem_fill_data = '0;
    for (int i = 0; i < fire_q.size(); i++) begin
      if (fire_q[i].c == cyc) begin
        bus.mem_fill      = 1'b1;
        bus.mem_fill_addr = fire_q[i].a;
        bus.mem_fill_data = fire_q[i].d;
        fire_q.delete(i);
        break;
      end
    end
  end

  // Scoreboard: every client fill must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.ic_fill || bus.dc_fill) begin
      chk("fill_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fill_owner", {bus.ic_fill, bus.dc_fill},
            e.who == IC ? 2'b10 : 2'b01);
        chk("fill_cycle", cyc, e.c);
        chk("fill_data",
            e.who == IC ? bus.ic_fill_data : bus.dc_fill_data, e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_store"}, bus.mem_req_store, 0);
    chk({tag, "_mem_addr"}, bus.mem_req_addr, 0);
    chk({tag, "_mem_evict"}, bus.mem_req_evict_data, 0);
    chk({tag, "_ic_fill"}, bus.ic_fill, 0);
    chk({tag, "_ic_data"}, bus.ic_fill_data, 0);
    chk({tag, "_dc_fill"}, bus.dc_fill, 0);
    chk({tag, "_dc_data"}, bus.dc_fill_data, 0);
    chk({tag, "_dc_ack"}, bus.dc_store_ack, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    bus.dc_req_store = 1'b0;
    bus.ic_req_addr = '0;
    bus.dc_req_addr = '0;
    bus.dc_req_evict_data = '0;
    step();
    step();
    outs_zero(tag);
    reset_n = 1'b1;
  endtask

  // Act as both caches: drop req in the cycle its fill/ack shows.
  task automatic run_clients(input string tag, input int budget);
    int n = 0;
    while ((bus.ic_req || bus.dc_req) && n < budget) begin
      step();
      n++;
      if (bus.ic_fill) bus.ic_req = 1'b0;
      if (bus.dc_fill || bus.dc_store_ack) bus.dc_req = 1'b0;
    end
    chk({tag, "_clients_done"}, bus.ic_req || bus.dc_req, 0);
  endtask

  task automatic chk_log(input string tag, input int c,
                         input logic st, input addr_t a);
    log_t l;
    chk({tag, "_present"}, log_q.size() != 0, 1'b1);
    if (log_q.size() != 0) begin
      l = log_q.pop_front();
      chk({tag, "_cycle"}, l.c, c);
      chk({tag, "_store"}, l.st, st);
      chk({tag, "_addr"}, l.a, a);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int    c0;
    line_t aa;
    aa = {16{8'hAA}};
    bus.mem_fill = 1'b0;
    bus.mem_fill_addr = '0;
    bus.mem_fill_data = '0;

    // Lone IC read, unaligned address
    do_reset("rst1");
    c0 = cyc;
    bus.ic_req = 1'b1;
    bus.ic_req_addr = 32'h104;
    exp_q.push_back('{IC, rd_line(32'h100), c0 + 7});
    run_clients("s1", 40);
    chk_log("s1_req", c0 + 1, 1'b0, 32'h100);
    chk("s1_log_empty", log_q.size(), 0);

    // Simultaneous requests: DC wins after reset
    do_reset("rst2");
    c0 = cyc;
    bus.dc_req = 1'b1;
    bus.dc_req_store = 1'b0;
    bus.dc_req_addr = 32'h30c;
    bus.ic_req = 1'b1;
    bus.ic_req_addr = 32'h140;
    exp_q.push_back('{DC, rd_line(32'h300), c0 + 7});
    exp_q.push_back('{IC, rd_line(32'h140), c0 + 15});
    run_clients("s2", 60);
    chk_log("s2_dc_req", c0 + 1, 1'b0, 32'h300);
    chk_log("s2_ic_req", c0 + 9, 1'b0, 32'h140);
    chk("s2_log_empty", log_q.size(), 0);

    // Store then read of the same line
    do_reset("rst3");
    c0 = cyc;
    bus.dc_req = 1'b1;
    bus.dc_req_store = 1'b1;
    bus.dc_req_addr = 32'h200;
    bus.dc_req_evict_data = aa;
    run_clients("s3_store", 20);
    chk("s3_ack_cycle", cyc, c0 + 1);
    chk("s3_evict_out", bus.mem_req_evict_data, aa);
    step();
    bus.dc_req = 1'b1;
    bus.dc_req_store = 1'b0;
    bus.dc_req_evict_data = '0;
    exp_q.push_back('{DC, aa, c0 + 13});
    run_clients("s3_read", 40);
    chk_log("s3_st_req", c0 + 1, 1'b1, 32'h200);
    chk_log("s3_rd_req", c0 + 7, 1'b0, 32'h200);
    chk("s3_err", err, 0);
    chk("s3_log_empty", log_q.size(), 0);

    // Wrong-address fill, then the right one
    do_reset("rst4");
    auto_resp = 1'b0;
    c0 = cyc;
    bus.ic_req = 1'b1;
    bus.ic_req_addr = 32'h700;
    fire_q.push_back('{c0 + 3, 32'h800, 128'hdead});
    fire_q.push_back('{c0 + 6, 32'h700, rd_line(32'h700)});
    exp_q.push_back('{IC, rd_line(32'h700), c0 + 7});
    step();
    step();
    step();
    chk("s4_err_before", err, 0);
    step();
    chk("s4_err_after", err, 1);
    run_clients("s4", 30);
    chk("s4_err_sticky", err, 1);
    auto_resp = 1'b1;
    chk_log("s4_req", c0 + 1, 1'b0, 32'h700);
    chk("s4_log_empty", log_q.size(), 0);

    // Memory never answers: timeout then re-issue
    do_reset("rst5");
    auto_resp = 1'b0;
    c0 = cyc;
    bus.dc_req = 1'b1;
    bus.dc_req_store = 1'b0;
    bus.dc_req_addr = 32'h900;
    for (int i = 0; i < 7; i++) step();
    chk("s5_err_before", err, 0);
    step();
    chk("s5_err_timeout", err, 1);
    auto_resp = 1'b1;
    exp_q.push_back('{DC, rd_line(32'h900), c0 + 15});
    run_clients("s5", 40);
    chk_log("s5_req1", c0 + 1, 1'b0, 32'h900);
    chk_log("s5_req2", c0 + 9, 1'b0, 32'h900);
    chk("s5_log_empty", log_q.size(), 0);

    // Reset mid-read; stale fill must be dropped
    do_reset("rst6");
    c0 = cyc;
    bus.ic_req = 1'b1;
    bus.ic_req_addr = 32'ha00;
    step();
    step();
    step();
    reset_n = 1'b0;
    bus.ic_req = 1'b0;
    step();
    outs_zero("s6_mid");
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s6_no_fill", bus.ic_fill || bus.dc_fill, 0);
      chk("s6_no_err", err, 0);
      chk("s6_no_req", bus.mem_req, 0);
    end
    chk("s6_stale_sent", fire_q.size(), 0);
    chk_log("s6_req", c0 + 1, 1'b0, 32'ha00);
    chk("s6_log_empty", log_q.size(), 0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
